// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls frames from an upstream synchronous FIFO.
// Frame: start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
// The serial line is driven from a register, so tx follows the state by one cycle.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW  = $clog2(WIDTH) + 1;

  localparam logic [BaudW-1:0] BaudLast  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(WIDTH - 1);
  localparam logic             ParityEn  = (PARITY_EN != 0);
  localparam logic             ParityOdd = (PARITY_ODD != 0);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StStart  = 3'd2;
  localparam logic [2:0] StData   = 3'd3;
  localparam logic [2:0] StParity = 3'd4;
  localparam logic [2:0] StStop   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             baud_last;
  logic             bit_last;

  assign baud_last = (baud_q == BaudLast);
  assign bit_last  = (idx_q == IdxLast);

  // Pop request is combinational so the FIFO sees it in the same IDLE cycle; gated by reset
  // because state_q sits at IDLE while reset is held.
  assign fifo_rd_en = rst & (state_q == StIdle) & tx_en & ~fifo_empty;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StStop) & baud_last;
  assign tx         = tx_q;

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (fifo_rd_en) state_d = StFetch;
      StFetch:  state_d = StStart;
      StStart:  if (baud_last) state_d = StData;
      StData:   if (baud_last && bit_last) state_d = ParityEn ? StParity : StStop;
      StParity: if (baud_last) state_d = StStop;
      StStop:   if (baud_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Baud counter: wraps every bit period and restarts on any state change.
  always_comb begin
    baud_d = baud_q + BaudW'(1);
    if (baud_last || (state_d != state_q) || (state_q == StIdle) || (state_q == StFetch)) begin
      baud_d = '0;
    end
  end

  // Bit index: cleared on DATA entry, advanced at the end of every data bit but the last.
  always_comb begin
    idx_d = idx_q;
    if ((state_d == StData) && (state_q != StData)) begin
      idx_d = '0;
    end else if ((state_q == StData) && baud_last && !bit_last) begin
      idx_d = idx_q + IdxW'(1);
    end
  end

  // Shift register and parity: loaded only in FETCH, data shifted out LSB first.
  always_comb begin
    shift_d  = shift_q;
    parity_d = parity_q;
    if (state_q == StFetch) begin
      shift_d  = fifo_rd_data;
      parity_d = (^fifo_rd_data) ^ ParityOdd;
    end else if ((state_q == StData) && baud_last) begin
      shift_d = shift_q >> 1;
    end
  end

  // Serial line level for the current state, registered next edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even parity, odd parity) fed from
// per-instance FIFO queues, compared cycle by cycle against a frame-timing model.
module tb_fifo_uart_tx;

  localparam int Cpb = 16;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty   [3];
  logic [7:0] fifo_rd_data [3];
  logic       fifo_rd_en   [3];
  logic       tx           [3];
  logic       busy         [3];
  logic       frame_done   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_uart_tx #(
      .WIDTH        (8),
      .CLKS_PER_BIT (Cpb),
      .PARITY_EN    ((g > 0) ? 1 : 0),
      .PARITY_ODD   ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .tx_en        (tx_en),
      .fifo_empty   (fifo_empty[g]),
      .fifo_rd_data (fifo_rd_data[g]),
      .fifo_rd_en   (fifo_rd_en[g]),
      .tx           (tx[g]),
      .busy         (busy[g]),
      .frame_done   (frame_done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Stimulus commands, applied just after each rising edge.
  logic rst_cmd;
  logic en_cmd;

  logic [7:0] fq [3][$];
  logic       pend_pop [3];
  int         pops     [3];
  int         fds      [3];

  // Model: cycle of the accepted pop (-1 when no frame) and the byte it carries.
  int         pc    [3];
  logic [7:0] mdata [3];
  logic       partx [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int frame_len(input int d);
    return (d > 0) ? 11 * Cpb : 10 * Cpb;
  endfunction

  // Expected line level k cycles into the transmitted frame.
  function automatic logic exp_bit(input int d, input int k);
    int         b;
    logic [7:0] v;
    b = k / Cpb;
    v = mdata[d];
    if (b == 0) return 1'b0;
    if (b <= 8) return v[b-1];
    if (d > 0 && b == 9) return (^v) ^ (d == 2);
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] v);
    for (int d = 0; d < 3; d++) fq[d].push_back(v);
  endtask

  task automatic cycle();
    int   len;
    int   k;
    logic busy_e;
    logic fd_e;
    logic tx_e;
    logic rd_e;
    @(posedge clk);
    #1;
    cyc++;
    rst   = rst_cmd;
    tx_en = en_cmd;
    for (int d = 0; d < 3; d++) begin
      if (pend_pop[d] && fq[d].size() > 0) fifo_rd_data[d] = fq[d].pop_front();
      else fifo_rd_data[d] = 8'($urandom);
      fifo_empty[d] = (fq[d].size() == 0);
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      if (!rst) pc[d] = -1;
      len    = frame_len(d);
      busy_e = (pc[d] >= 0) && (cyc >= pc[d] + 1) && (cyc <= pc[d] + 1 + len);
      fd_e   = (pc[d] >= 0) && (cyc == pc[d] + 1 + len);
      k      = cyc - (pc[d] + 3);
      tx_e   = (pc[d] >= 0 && k >= 0 && k < len) ? exp_bit(d, k) : 1'b1;
      rd_e   = rst && !busy_e && tx_en && !fifo_empty[d];
      check($sformatf("tx%0d", d), 32'(tx[d]), 32'(tx_e));
      check($sformatf("busy%0d", d), 32'(busy[d]), 32'(busy_e));
      check($sformatf("frame_done%0d", d), 32'(frame_done[d]), 32'(fd_e));
      check($sformatf("rd_en%0d", d), 32'(fifo_rd_en[d]), 32'(rd_e));
      if (d > 0 && pc[d] >= 0 && cyc == pc[d] + 3 + 9 * Cpb + 8) partx[d] = tx[d];
      if (rd_e) begin
        pc[d]    = cyc;
        mdata[d] = fq[d][0];
      end
      pend_pop[d] = fifo_rd_en[d];
      if (fifo_rd_en[d]) pops[d]++;
      if (frame_done[d]) fds[d]++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 3; d++) begin
      pops[d] = 0;
      fds[d]  = 0;
    end
  endtask

  initial begin
    rst     = 1'b0;
    rst_cmd = 1'b0;
    tx_en   = 1'b1;
    en_cmd  = 1'b1;
    for (int d = 0; d < 3; d++) begin
      fifo_empty[d]   = 1'b1;
      fifo_rd_data[d] = 8'h00;
      pend_pop[d]     = 1'b0;
      pc[d]           = -1;
      mdata[d]        = 8'h00;
      partx[d]        = 1'bx;
    end
    clear_counts();

    // Reset held with a non-empty FIFO and tx_en high, then single byte 0xA5.
    push(8'hA5);
    run(6);
    for (int d = 0; d < 3; d++) check($sformatf("reset_pops%0d", d), 32'(pops[d]), 32'd0);
    rst_cmd = 1'b1;
    run(200);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("a5_pops%0d", d), 32'(pops[d]), 32'd1);
      check($sformatf("a5_done%0d", d), 32'(fds[d]), 32'd1);
    end

    // Back-to-back 0x00 then 0xFF.
    clear_counts();
    push(8'h00);
    push(8'hFF);
    run(420);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("b2b_pops%0d", d), 32'(pops[d]), 32'd2);
      check($sformatf("b2b_done%0d", d), 32'(fds[d]), 32'd2);
    end

    // Parity bit for 0x07.
    partx[1] = 1'bx;
    partx[2] = 1'bx;
    push(8'h07);
    run(200);
    check("parity_even", 32'(partx[1]), 32'd1);
    check("parity_odd", 32'(partx[2]), 32'd0);

    // Reset during data bit 3 of 0x11; 0x3C follows after release.
    clear_counts();
    push(8'h11);
    push(8'h3C);
    run(75);
    rst_cmd = 1'b0;
    run(3);
    rst_cmd = 1'b1;
    run(200);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_pops%0d", d), 32'(pops[d]), 32'd2);
      check($sformatf("rst_done%0d", d), 32'(fds[d]), 32'd1);
    end

    // tx_en low blocks pops; dropping it mid-frame lets the frame finish.
    en_cmd = 1'b0;
    push(8'h55);
    run(40);
    for (int d = 0; d < 3; d++) check($sformatf("en_hold%0d", d), 32'(fq[d].size()), 32'd1);
    en_cmd = 1'b1;
    push(8'h66);
    run(60);
    en_cmd = 1'b0;
    run(200);
    for (int d = 0; d < 3; d++) check($sformatf("en_drop%0d", d), 32'(fq[d].size()), 32'd1);
    en_cmd = 1'b1;
    run(200);

    // Randomized traffic with tx_en toggles and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0 && fq[0].size() < 4) push(8'($urandom));
      if ($urandom_range(0, 149) == 0) en_cmd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_cmd = 1'b0;
        run($urandom_range(1, 3));
        rst_cmd = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2 and above).
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tx_en  input  1  permits starting new frames.
REQ-008 SHALL have port fifo_empty  input  1  empty flag from upstream synchronous FIFO.
REQ-009 SHALL have port fifo_rd_data  input  WIDTH  FIFO read data, valid on the cycle after a fifo_rd_en pulse.
REQ-010 SHALL have port fifo_rd_en  output  1  pop request to the FIFO.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on the final stop-bit cycle.

Function
REQ-014 SHALL implement the states IDLE, FETCH, START, DATA, PARITY and STOP.
REQ-015 IDLE: fifo_rd_en SHALL be combinational and equal to (state==IDLE && tx_en && !fifo_empty); when it is 1, the next state SHALL be FETCH.
REQ-016 fifo_rd_en SHALL never be high outside IDLE, and SHALL never be high for two consecutive cycles.
REQ-017 FETCH: lasts exactly 1 cycle; SHALL load fifo_rd_data into the shift register, compute parity over WIDTH bits, then go to START.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: SHALL send WIDTH bits LSB first, each for CLKS_PER_BIT cycles; after the last bit go to PARITY if PARITY_EN=1, else STOP.
REQ-020 PARITY: tx = XOR of data bits for even parity, inverted for odd parity, for CLKS_PER_BIT cycles, then STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 on the last of these cycles; then go to IDLE.
REQ-022 tx SHALL be registered and glitch-free; tx=1 in IDLE and FETCH.
REQ-023 Latency: tx SHALL fall at the second rising edge after the edge that samples fifo_rd_en=1.
REQ-024 Frame length SHALL be (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles, measured from START entry to STOP exit.
REQ-025 Back-to-back: with the FIFO non-empty and tx_en=1, the gap from STOP exit to the next START SHALL be exactly 2 cycles (IDLE + FETCH).
REQ-026 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0 to CLKS_PER_BIT-1, and clear on every state change.
REQ-027 The bit index counter SHALL be $clog2(WIDTH)+1 bits wide and clear on entry to DATA.
REQ-028 tx_en deasserted mid-frame SHALL NOT abort the frame; only the next IDLE-to-FETCH transition is blocked.
REQ-029 fifo_empty rising during FETCH or later SHALL NOT affect the current frame.
REQ-030 fifo_rd_data SHALL be sampled only in FETCH.

Reset
REQ-031 While rst=0: state=IDLE, tx=1, busy=0, frame_done=0, fifo_rd_en=0, counters=0, shift register=0; all asynchronous and immediate.
REQ-032 Reset asserted mid-frame SHALL drive tx=1 immediately; the in-flight byte is discarded, no frame_done is issued and no extra FIFO pop occurs.
REQ-033 After reset release, the first possible fifo_rd_en SHALL be on the first rising edge with rst=1.

Verification (WIDTH=8, CLKS_PER_BIT=16)
REQ-034 Reset: rst=0 with fifo_empty=0 and tx_en=1 -> tx=1, busy=0, fifo_rd_en=0 for the whole reset duration.
REQ-035 Single byte 0xA5, PARITY_EN=0 -> one fifo_rd_en pulse; tx=0 for 16 cycles; then bits 1,0,1,0,0,1,0,1 at 16 cycles each; then stop high for 16 cycles; frame_done on cycle 160 of the frame; busy low afterwards.
REQ-036 Back-to-back 0x00 then 0xFF, FIFO held non-empty -> tx high for 18 cycles between frames (16 stop + 2); exactly 2 fifo_rd_en pulses.
REQ-037 Parity: PARITY_EN=1, byte 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame length 176 cycles.
REQ-038 Reset during data bit 3 -> tx=1 at once, no frame_done; next byte 0x3C, after release, transmits a correct full frame.
REQ-039 tx_en=0 with FIFO non-empty -> no fifo_rd_en; tx_en dropped mid-frame -> current frame completes and no further pop occurs.
